// File: rtl/cache_pkg.sv
// Shared widths and memory-side FSM state encodings for the cache write buffer.
package cache_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/wbuf_entry_array.sv
// Circular store of buffered writeback blocks: per-entry valid/addr/data,
// head/tail/count bookkeeping and a parallel address-match vector.
module wbuf_entry_array #(
  parameter  int DEPTH  = 4,
  parameter  int ADDR_W = 28,
  parameter  int DATA_W = 128,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              push,
  input  logic              coalesce,
  input  logic [IDX_W-1:0]  coal_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] match_addr,
  output logic [DEPTH-1:0]  match_vec,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  head,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [IDX_W-1:0]  tail;

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (push) begin
        valid[tail]  <= 1'b1;
        addr_q[tail] <= wr_addr;
        tail         <= tail + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Block data needs no reset: an entry is only read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push)          data_q[tail]     <= wr_data;
    else if (coalesce) data_q[coal_idx] <= wr_data;
  end

  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      match_vec[i] = valid[i] && (addr_q[i] == match_addr);
  end

  assign rd_data   = data_q[rd_idx];
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

endmodule

// File: rtl/cache_write_buffer.sv
// Posted write buffer between the direct-mapped cache and block memory:
// coalesces/queues writebacks, serves read hits, forwards misses.
module cache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_empty
);

  import cache_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  mem_state_t        state;
  logic [DEPTH-1:0]  match_vec, drain_vec, nd_match;
  logic [IDX_W-1:0]  head, nd_idx, hit_idx;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data, rd_data;
  logic              rd_req, wr_req, rd_hit, rd_miss;
  logic              coalesce, push, pop, fwd_head;

  wbuf_entry_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_entries (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .push         (push),
    .coalesce     (coalesce),
    .coal_idx     (nd_idx),
    .wr_addr      (c_addr),
    .wr_data      (c_wdata),
    .pop          (pop),
    .match_addr   (c_addr),
    .match_vec    (match_vec),
    .rd_idx       (hit_idx),
    .rd_data      (rd_data),
    .head         (head),
    .count        (count),
    .head_addr    (head_addr),
    .head_data    (head_data)
  );

  always_comb begin
    rd_req    = c_read && !c_ready;
    wr_req    = c_write && !c_read && !c_ready;
    drain_vec = '0;
    if (state == M_WRITE) drain_vec[head] = 1'b1;
    nd_match  = match_vec & ~drain_vec;
    nd_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (nd_match[i]) nd_idx = IDX_W'(i);
    // Non-draining copy is newest; otherwise the only match is the draining head.
    hit_idx   = (|nd_match) ? nd_idx : head;
    rd_hit    = rd_req && (|match_vec);
    rd_miss   = rd_req && !(|match_vec);
    coalesce  = wr_req && (|nd_match);
    push      = wr_req && !(|nd_match) && (count < CNT_W'(DEPTH));
    pop       = (state == M_WRITE) && mem_ready;
    fwd_head  = coalesce && (nd_idx == head);
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state     <= M_IDLE;
      c_ready   <= 1'b0;
      c_rdata   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_empty  <= 1'b1;
    end else begin
      c_ready  <= coalesce || push || rd_hit;
      if (rd_hit) c_rdata <= rd_data;
      wb_empty <= 1'b0;
      case (state)
        M_IDLE: begin
          if (rd_miss) begin
            state    <= M_READ;
            mem_read <= 1'b1;
            mem_addr <= c_addr;
          end else if (count != '0) begin
            state     <= M_WRITE;
            mem_write <= 1'b1;
            mem_addr  <= head_addr;
            // A coalesce into the head on the launch edge must reach memory too.
            mem_wdata <= fwd_head ? c_wdata : head_data;
          end else begin
            wb_empty <= (count_nxt == '0);
          end
        end
        M_WRITE: begin
          if (mem_ready) begin
            state     <= M_IDLE;
            mem_write <= 1'b0;
            wb_empty  <= (count_nxt == '0);
          end
        end
        M_READ: begin
          if (mem_ready) begin
            state    <= M_IDLE;
            mem_read <= 1'b0;
            c_ready  <= 1'b1;
            c_rdata  <= mem_rdata;
            wb_empty <= (count_nxt == '0);
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

endmodule
